// File: rtl/datapath_seq_if.sv
// Bundle between the instruction decoder and the sequenced datapath:
// the operation request fields, the handshake/status outputs and the debug read port.
interface datapath_seq_if #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int PC_W  = 8
);
   localparam int AW = $clog2(NREGS);

   logic             start;
   logic [1:0]       op;
   logic [1:0]       shift;
   logic             asel_zero;
   logic             use_imm;
   logic [1:0]       vsel;
   logic [AW-1:0]    rn;
   logic [AW-1:0]    rm;
   logic [AW-1:0]    rd;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] mdata;
   logic [PC_W-1:0]  pc;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] datapath_out;
   logic             Z_out;
   logic             N_out;
   logic             V_out;
   logic [AW-1:0]    dbg_addr;
   logic [WIDTH-1:0] dbg_data;

   // Decoder side: issues operations and watches completion.
   modport master (
      output start, op, shift, asel_zero, use_imm, vsel, rn, rm, rd, imm, mdata, pc, dbg_addr,
      input  busy, done, datapath_out, Z_out, N_out, V_out, dbg_data
   );

   // Datapath side.
   modport slave (
      input  start, op, shift, asel_zero, use_imm, vsel, rn, rm, rd, imm, mdata, pc, dbg_addr,
      output busy, done, datapath_out, Z_out, N_out, V_out, dbg_data
   );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequencing register-file datapath: one operation per start handshake,
// stepped through operand load (LA, LB), execute (EX) and writeback (WB).
// Non-ALU writebacks (imm, mdata, pc) skip straight from IDLE to WB.
module datapath_seq #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int PC_W  = 8
) (
   input logic            clk,
   input logic            reset,
   datapath_seq_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LA   = 3'd1;
   localparam logic [2:0] S_LB   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             done_q, done_d;
   logic [1:0]       op_q, op_d;
   logic [1:0]       shift_q, shift_d;
   logic             asel_zero_q, asel_zero_d;
   logic             use_imm_q, use_imm_d;
   logic [1:0]       vsel_q, vsel_d;
   logic [AW-1:0]    rn_q, rn_d;
   logic [AW-1:0]    rm_q, rm_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             v_q, v_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];

   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bsh;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] alu_res;
   logic             alu_v;
   logic [WIDTH-1:0] wb_val;

   // Operand selection, B shifter and ALU with signed-overflow detection.
   always_comb begin
      ain = asel_zero_q ? '0 : a_q;
      case (shift_q)
         2'b00:   bsh = b_q;
         2'b01:   bsh = {b_q[WIDTH-2:0], 1'b0};
         2'b10:   bsh = {1'b0, b_q[WIDTH-1:1]};
         default: bsh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      endcase
      bin = use_imm_q ? imm_q : bsh;
      alu_res = '0;
      alu_v   = 1'b0;
      case (op_q)
         2'b00: begin
            alu_res = ain + bin;
            alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
         end
         2'b01: begin
            alu_res = ain - bin;
            alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
         end
         2'b10:   alu_res = ain & bin;
         default: alu_res = ~bin;
      endcase
   end

   // Writeback source; memory data is taken live at the WB edge, pc is zero-extended.
   always_comb begin
      case (vsel_q)
         2'b00:   wb_val = c_q;
         2'b01:   wb_val = imm_q;
         2'b10:   wb_val = bus.mdata;
         default: wb_val = WIDTH'(pc_q);
      endcase
   end

   // Sequencer: latches the request in IDLE, then walks the phases of the operation.
   always_comb begin
      state_d     = state_q;
      done_d      = 1'b0;
      op_d        = op_q;
      shift_d     = shift_q;
      asel_zero_d = asel_zero_q;
      use_imm_d   = use_imm_q;
      vsel_d      = vsel_q;
      rn_d        = rn_q;
      rm_d        = rm_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      z_d         = z_q;
      n_d         = n_q;
      v_d         = v_q;
      regs_d      = regs_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d        = bus.op;
               shift_d     = bus.shift;
               asel_zero_d = bus.asel_zero;
               use_imm_d   = bus.use_imm;
               vsel_d      = bus.vsel;
               rn_d        = bus.rn;
               rm_d        = bus.rm;
               rd_d        = bus.rd;
               imm_d       = bus.imm;
               pc_d        = bus.pc;
               state_d     = (bus.vsel == 2'b00) ? S_LA : S_WB;
            end
         end
         S_LA: begin
            a_d     = regs_q[rn_q];
            state_d = S_LB;
         end
         S_LB: begin
            b_d     = regs_q[rm_q];
            state_d = S_EX;
         end
         S_EX: begin
            c_d     = alu_res;
            z_d     = (alu_res == '0);
            n_d     = alu_res[WIDTH-1];
            v_d     = alu_v;
            state_d = S_WB;
         end
         S_WB: begin
            regs_d[rd_q] = wb_val;
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, request latches, datapath registers and register file; reset aborts everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         done_q      <= 1'b0;
         op_q        <= '0;
         shift_q     <= '0;
         asel_zero_q <= 1'b0;
         use_imm_q   <= 1'b0;
         vsel_q      <= '0;
         rn_q        <= '0;
         rm_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         op_q        <= op_d;
         shift_q     <= shift_d;
         asel_zero_q <= asel_zero_d;
         use_imm_q   <= use_imm_d;
         vsel_q      <= vsel_d;
         rn_q        <= rn_d;
         rm_q        <= rm_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         z_q         <= z_d;
         n_q         <= n_d;
         v_q         <= v_d;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = done_q;
   assign bus.datapath_out = c_q;
   assign bus.Z_out        = z_q;
   assign bus.N_out        = n_q;
   assign bus.V_out        = v_q;
   assign bus.dbg_data     = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_datapath_seq.sv
// Directed testbench for datapath_seq: immediate/memory/pc writebacks, ALU ops with
// shifter and flags, latency, busy/done handshake, reset abort and back-to-back start.
module tb_datapath_seq;
   logic clk;
   logic reset;
   int   checks;
   int   passes;

   datapath_seq_if #(.WIDTH(16), .NREGS(8), .PC_W(8)) bus ();

   datapath_seq #(.WIDTH(16), .NREGS(8), .PC_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         passes++;
   endtask

   // Reads one register through the debug port.
   task automatic checkReg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
      bus.dbg_addr = addr;
      #1;
      checkOutput(tag, bus.dbg_data, exp);
   endtask

   // Checks C register and status flags together.
   task automatic checkStatus(input string tag, input logic [15:0] c, input logic z,
                              input logic n, input logic v);
      checkOutput({tag, "_C"}, bus.datapath_out, c);
      checkOutput({tag, "_Z"}, bus.Z_out, z);
      checkOutput({tag, "_N"}, bus.N_out, n);
      checkOutput({tag, "_V"}, bus.V_out, v);
   endtask

   // Drives all request fields of the interface.
   task automatic setFields(input logic [1:0] op, input logic [1:0] shift, input logic aselZero,
                            input logic useImm, input logic [1:0] vsel, input logic [2:0] rn,
                            input logic [2:0] rm, input logic [2:0] rd, input logic [15:0] imm,
                            input logic [7:0] pc);
      bus.op        = op;
      bus.shift     = shift;
      bus.asel_zero = aselZero;
      bus.use_imm   = useImm;
      bus.vsel      = vsel;
      bus.rn        = rn;
      bus.rm        = rm;
      bus.rd        = rd;
      bus.imm       = imm;
      bus.pc        = pc;
   endtask

   // Issues one operation, changes mdata during the busy window, and checks the latency.
   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [1:0] shift,
                                input logic aselZero, input logic useImm, input logic [1:0] vsel,
                                input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                                input logic [15:0] imm, input logic [7:0] pc,
                                input logic [15:0] mdataStart, input logic [15:0] mdataLate,
                                input int expLat);
      int edges;
      @(negedge clk);
      setFields(op, shift, aselZero, useImm, vsel, rn, rm, rd, imm, pc);
      bus.mdata = mdataStart;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mdata = mdataLate;
      checkOutput({tag, "_busy"}, bus.busy, 1'b1);
      edges = 0;
      while (bus.done !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput({tag, "_lat"}, edges, expLat);
      checkOutput({tag, "_idle"}, bus.busy, 1'b0);
   endtask

   // Main directed sequence.
   initial begin
      int edges;
      int doneSeen;
      checks    = 0;
      passes    = 0;
      clk       = 1'b0;
      reset     = 1'b1;
      bus.start = 1'b0;
      setFields(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h00);
      bus.mdata    = 16'h0000;
      bus.dbg_addr = 3'd0;
      #12;
      checkOutput("rst_busy", bus.busy, 1'b0);
      checkOutput("rst_done", bus.done, 1'b0);
      checkStatus("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      checkReg("rst_r0", 3'd0, 16'h0000);
      @(negedge clk);
      reset = 1'b0;

      // Immediate writebacks complete one edge after acceptance.
      applyStimulus("imm_r1", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd1, 16'h0005, 8'h00, 16'h0, 16'h0, 1);
      checkReg("r1_imm", 3'd1, 16'h0005);
      applyStimulus("imm_r2", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd2, 16'hFFFD, 8'h00, 16'h0, 16'h0, 1);
      checkReg("r2_imm", 3'd2, 16'hFFFD);
      checkStatus("imm_keeps", 16'h0000, 1'b0, 1'b0, 1'b0);

      // 5 + (-3) = 2, carry discarded, no overflow.
      applyStimulus("add", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r3_add", 3'd3, 16'h0002);
      checkStatus("add", 16'h0002, 1'b0, 1'b0, 1'b0);

      // 5 - 5 = 0 sets Z; 0x7FFF + 0x7FFF overflows to 0xFFFE.
      applyStimulus("sub", 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 3'd1, 3'd4, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r4_sub", 3'd4, 16'h0000);
      checkStatus("sub", 16'h0000, 1'b1, 1'b0, 1'b0);
      applyStimulus("imm_r5", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd5, 16'h7FFF, 8'h00, 16'h0, 16'h0, 1);
      applyStimulus("addovf", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd5, 3'd5, 3'd5, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r5_ovf", 3'd5, 16'hFFFE);
      checkStatus("addovf", 16'hFFFE, 1'b0, 1'b1, 1'b1);

      // Shifter with A forced to zero: shl1(5)=0x000A, lsr1(0xFFFD)=0x7FFE, asr1(0xFFFD)=0xFFFE.
      applyStimulus("shl1", 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 3'd3, 3'd1, 3'd7, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r7_shl", 3'd7, 16'h000A);
      checkStatus("shl1", 16'h000A, 1'b0, 1'b0, 1'b0);
      applyStimulus("lsr1", 2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 3'd3, 3'd2, 3'd7, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r7_lsr", 3'd7, 16'h7FFE);
      checkStatus("lsr1", 16'h7FFE, 1'b0, 1'b0, 1'b0);
      applyStimulus("asr1", 2'b00, 2'b11, 1'b1, 1'b0, 2'b00, 3'd3, 3'd2, 3'd7, 16'h0000, 8'h00, 16'h0, 16'h0, 4);
      checkReg("r7_asr", 3'd7, 16'hFFFE);
      checkStatus("asr1", 16'hFFFE, 1'b0, 1'b1, 1'b0);

      // Memory data is taken at the WB edge; pc is zero-extended; status untouched.
      applyStimulus("mdata", 2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 3'd0, 3'd0, 3'd0, 16'h0000, 8'h00, 16'h1111, 16'h1234, 1);
      checkReg("r0_mdata", 3'd0, 16'h1234);
      checkStatus("mdata", 16'hFFFE, 1'b0, 1'b1, 1'b0);
      applyStimulus("pc", 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'd0, 3'd0, 3'd0, 16'h0000, 8'hAB, 16'h0, 16'h0, 1);
      checkReg("r0_pc", 3'd0, 16'h00AB);
      checkStatus("pc", 16'hFFFE, 1'b0, 1'b1, 1'b0);

      // Reset while in EX of an add to r6: aborted, no writeback, no done.
      @(negedge clk);
      setFields(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 3'd1, 3'd6, 16'h0000, 8'h00);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("ex_busy", bus.busy, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", bus.busy, 1'b0);
      checkOutput("abort_done", bus.done, 1'b0);
      checkStatus("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      doneSeen = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (bus.done) doneSeen++;
      end
      checkOutput("abort_nodone", doneSeen, 0);
      checkReg("r6_abort", 3'd6, 16'h0000);
      checkReg("r7_cleared", 3'd7, 16'h0000);

      // Start while busy is dropped; start in the done cycle is accepted.
      applyStimulus("imm_r1b", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd1, 16'h0003, 8'h00, 16'h0, 16'h0, 1);
      applyStimulus("imm_r2b", 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd2, 16'h0004, 8'h00, 16'h0, 16'h0, 1);
      @(negedge clk);
      setFields(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0000, 8'h00);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      setFields(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd4, 16'h0055, 8'h00);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      edges = 1;
      while (bus.done !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput("b2b_lat", edges, 4);
      checkOutput("b2b_idle", bus.busy, 1'b0);
      checkReg("r3_b2b", 3'd3, 16'h0007);
      setFields(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'd0, 3'd0, 3'd5, 16'h0066, 8'h00);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checkOutput("done_cycle_accept", bus.busy, 1'b1);
      checkOutput("done_pulse_once", bus.done, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("b2b_done", bus.done, 1'b1);
      checkReg("r5_b2b", 3'd5, 16'h0066);
      checkReg("r4_not_queued", 3'd4, 16'h0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
Parametrised, self-sequencing successor of the lab CPU datapath. It accepts one register-to-register, immediate, memory-data or PC-write operation per start handshake. An internal FSM steps through the operand-load, execute and writeback phases and pulses done on completion. Register file width and depth, and PC width, are set by parameters. Sits between the instruction decoder (which issues start plus fields) and memory/PC logic.

Parameters:
WIDTH, 16, datapath and register width (>=4)
NREGS, 8, register file depth (power of 2, >=2); AW = clog2(NREGS)
PC_W, 8, PC input width (<= WIDTH)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  operation request; accepted only while busy=0
op  in  2  ALU op: 00 add, 01 sub, 10 and, 11 not B
shift  in  2  B shifter: 00 pass, 01 shl1 (lsb 0), 10 lsr1 (msb 0), 11 asr1 (msb kept)
asel_zero  in  1  1: ALU A input = 0
use_imm  in  1  1: ALU B input = imm (shifter bypassed)
vsel  in  2  writeback source: 00 ALU/C, 01 imm, 10 mdata, 11 zero-extended pc
rn, rm, rd  in  AW  A-source, B-source and destination register indices
imm  in  WIDTH  pre-sign-extended immediate
mdata  in  WIDTH  memory read data
pc  in  PC_W  program counter
busy  out  1  high while FSM is not in IDLE
done  out  1  one-cycle completion pulse
datapath_out  out  WIDTH  C register
Z_out, N_out, V_out  out  1  status register
dbg_addr  in  AW  debug read index
dbg_data  out  WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, immediate): all regfile entries = 0; A, B, C, Z, N, V = 0; FSM = IDLE; busy = 0; done = 0. Reset during any state aborts the operation with no writeback and no status update.
- At the accepting edge, latch start, op, shift, asel_zero, use_imm, vsel, rn, rm, rd, imm and pc. Input changes while busy are ignored. start while busy is ignored, not queued.
- mdata is sampled live at the WB edge.
- States: IDLE, LA, LB, EX, WB.
- IDLE: start=1 and vsel=00 goes to LA. start=1 and vsel!=00 goes directly to WB.
- LA: A <= reg[rn]. Go to LB.
- LB: B <= reg[rm]. Go to EX.
- EX: C <= ALU result; Z/N/V <= flags. Go to WB.
- WB: reg[rd] <= selected source. Go to IDLE; done <= 1 for exactly one cycle.
- Latency: start accepted at edge k. For vsel=00, write and done at edge k+4. For vsel!=00, write and done at edge k+1.
- Non-ALU ops leave A, B, C and status unchanged.
- Back-to-back: FSM is IDLE while done is high, so start may be accepted in the done cycle.
- ALU input selection: Ain = asel_zero ? 0 : A. Bin = use_imm ? imm : shift(B).
- ALU arithmetic is modulo 2^WIDTH; carry is discarded.
- Z = (result == 0). N = result[WIDTH-1].
- V = signed overflow for add/sub (operands same sign for add / differing signs for sub, and result sign differs from Ain); V = 0 for and/not.
- Reads in LA/LB happen before WB, so rd may equal rn or rm and operands are the pre-write values.
- dbg_data reflects a write from the edge after WB.
- pc is zero-extended to WIDTH.

Test Plan:
1. Reset, then write imm via vsel=01 (rd=1 imm=5, rd=2 imm=-3 = 0xFFFD) -> done after 1 edge each; dbg_data reads 0x0005 and 0xFFFD; busy high exactly 1 cycle.
2. add rd=3, rn=1, rm=2, shift=00 -> done 4 edges after start; r3 = 0x0002; datapath_out = 0x0002; Z=0 N=0 V=0.
3. sub rd=4, rn=1, rm=1 -> r4 = 0; Z=1. Then load r5 = 0x7FFF and add r5+r5 -> 0xFFFE, N=1, V=1.
4. asr1 on r2 (0xFFFD) with asel_zero=1, op=add -> result 0xFFFE. lsr1 on the same value -> 0x7FFE. shl1 on r1 -> 0x000A.
5. vsel=10 with mdata changed to 0x1234 during the busy window -> the value present at the WB edge is written. vsel=11 with pc=0xAB -> 0x00AB. Status unchanged in both cases.
6. Assert reset in state EX of an add targeting r6 -> r6 stays 0, busy=0, done never pulses. start asserted while busy is ignored. start in the done cycle is accepted (busy goes high next edge).
